// File: rtl/lsu_if.sv
// ----------------------------------------------------------------------------
// lsu_if: bundle of every handshake and bus signal around the load/store unit.
//
//   EXU request   : in_valid, in_ready, in_wen, in_size, in_sext, in_addr,
//                   in_wdata
//   WBU response  : out_valid, out_ready, out_rdata, out_err
//   Memory port   : mem_valid, mem_raddr, mem_rdata, mem_wen, mem_waddr,
//                   mem_wdata, mem_wmask
//
// Modports:
//   slave  - the LSU itself (consumes requests, produces responses and
//            drives the memory port).
//   master - the surroundings: EXU, WBU and the memory model.
//
// Handshake rule (both in_* and out_* channels): a transfer happens on a
// rising clock edge where valid and ready are both high. Once raised, a
// valid holds its payload stable until that edge. Ready never depends
// combinationally on valid.
// ----------------------------------------------------------------------------
interface lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [1:0]  in_size;
    logic        in_sext;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    logic        mem_valid;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;

    modport slave (
        input  in_valid, in_wen, in_size, in_sext, in_addr, in_wdata,
        output in_ready,
        output out_valid, out_rdata, out_err,
        input  out_ready,
        output mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport master (
        output in_valid, in_wen, in_size, in_sext, in_addr, in_wdata,
        input  in_ready,
        input  out_valid, out_rdata, out_err,
        output out_ready,
        input  mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu: load/store unit. Takes one load or store at a time from EXU, issues a
// single-cycle request on the synchronous memory port, aligns store data and
// builds the byte mask, extends load data, and holds the result for WBU until
// it is taken.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous, active-low reset
//   bus          lsu_if.slave  EXU request, WBU response and memory port
//   o_dbg_state  out  current FSM state (IDLE=0, REQ=1, WAIT=2, RESP=3)
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses skip memory and complete with
//               out_err=1, out_rdata=0.
//   undefined - no check; out_err is tied 0 and misaligned accesses are
//               issued with lanes beyond byte 3 dropped.
// ----------------------------------------------------------------------------
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        bus,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_wen;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_misalign;
    logic [4:0]  w_shamt;
    logic [3:0]  w_base_mask;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_shifted;
    logic [31:0] w_load_val;

    assign o_dbg_state = r_state;
    assign w_accept    = (r_state == ST_IDLE) && bus.in_valid;

`ifdef LSU_MISALIGN_CHECK_EN
    // Checked on the incoming request so a bad access can bypass memory.
    always_comb begin
        w_misalign = 1'b0;
        case (bus.in_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = bus.in_addr[0];
            default: w_misalign = |bus.in_addr[1:0];
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Lane alignment helpers (all relative to the latched request)
    // ------------------------------------------------------------------
    assign w_shamt = {r_addr[1:0], 3'b000};

    always_comb begin
        w_base_mask = 4'b1111;
        case (r_size)
            2'b00:   w_base_mask = 4'b0001;
            2'b01:   w_base_mask = 4'b0011;
            default: w_base_mask = 4'b1111;
        endcase
    end

    // Shift stays 4 bits wide, so lanes past byte 3 fall off.
    assign w_lane_mask = w_base_mask << r_addr[1:0];

    assign w_shifted = bus.mem_rdata >> w_shamt;

    always_comb begin
        w_load_val = w_shifted;
        case (r_size)
            2'b00:   w_load_val = {{24{r_sext & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load_val = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_val = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_raddr = 32'h0;
        bus.mem_waddr = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wmask = 8'h00;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so ready is low for the whole reset pulse.
                bus.in_ready = rst_n;
                if (bus.in_valid) begin
                    w_next = w_misalign ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                bus.mem_valid = 1'b1;
                bus.mem_wen   = r_wen;
                bus.mem_raddr = {r_addr[31:2], 2'b00};
                bus.mem_waddr = {r_addr[31:2], 2'b00};
                bus.mem_wdata = r_wdata << w_shamt;
                bus.mem_wmask = {4'b0000, w_lane_mask};
                w_next        = r_wen ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_wen   <= bus.in_wen;
                r_size  <= bus.in_size;
                r_sext  <= bus.in_sext;
                r_addr  <= bus.in_addr;
                r_wdata <= bus.in_wdata;
                // Stores and rejected accesses report zero data.
                r_rdata <= 32'h0;
            end
            if (r_state == ST_WAIT) begin
                r_rdata <= w_load_val;
            end
        end
    end

    assign bus.out_rdata = r_rdata;

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end else if ((r_state == ST_RESP) && bus.out_ready) begin
            r_err <= 1'b0;
        end
    end

    assign bus.out_err = r_err;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu: self-checking bench for lsu. A transaction-level model (reference
// memory plus per-transaction expectations indexed by cycles since accept)
// is compared against the DUT every cycle; directed transactions pin the
// model with hand-computed literals, then randomized traffic runs.
// ----------------------------------------------------------------------------
module tb_lsu;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_if bus();
    logic [1:0] dbg_state;

    lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // ---------------- memory environment ----------------
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'h0;
    logic [31:0] env_mem [16];

    always @(posedge clk) begin
        if (pl_en) env_mem[pl_idx] <= pl_val;
        if (bus.mem_valid) begin
            if (bus.mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wmask[b]) env_mem[bus.mem_waddr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= env_mem[bus.mem_raddr[5:2]];
        end
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic mis_of(input logic [1:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return ((s == 2'b01) && a[0]) || ((s[1] == 1'b1) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] load_ref(input logic [31:0] word, input logic [1:0] s,
                                             input logic sx, input logic [1:0] off);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(s);
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 4) v[8*i +: 8] = word[8*(int'(off) + i) +: 8];
        if (n < 4 && sx && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] store_ref(input logic [31:0] word, input logic [31:0] d,
                                              input logic [1:0] s, input logic [1:0] off);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < nbytes(s); i++)
            if (int'(off) + i < 4) w[8*(int'(off) + i) +: 8] = d[8*i +: 8];
        return w;
    endfunction

    function automatic logic [7:0] mask_ref(input logic [1:0] s, input logic [1:0] off);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < nbytes(s); i++)
            if (int'(off) + i < 4) m[int'(off) + i] = 1'b1;
        return m;
    endfunction

    logic [31:0] ref_mem [16];
    int          cyc    = 0;
    logic        m_busy = 1'b0;
    int          m_acc  = 0;
    int          m_lat  = 0;
    logic        m_wen  = 1'b0;
    logic [1:0]  m_size = 2'b00;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_mis  = 1'b0;
    logic [31:0] m_rd   = 32'h0;

    // Transaction-level view: a request is taken whenever the LSU is free;
    // cycle k after accept: k==0 memory request (if issued), response from
    // k>=m_lat until out_ready is seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
        end else begin
            if (pl_en) ref_mem[pl_idx] = pl_val;
            if (m_busy) begin
                if ((cyc - m_acc) >= m_lat && bus.out_ready) m_busy = 1'b0;
            end else if (bus.in_valid) begin
                m_busy  = 1'b1;
                m_acc   = cyc + 1;
                m_wen   = bus.in_wen;
                m_size  = bus.in_size;
                m_addr  = bus.in_addr;
                m_wdata = bus.in_wdata;
                m_mis   = mis_of(bus.in_size, bus.in_addr);
                m_rd    = 32'h0;
                if (m_mis) begin
                    m_lat = 0;
                end else if (m_wen) begin
                    m_lat = 1;
                    ref_mem[m_addr[5:2]] = store_ref(ref_mem[m_addr[5:2]], m_wdata, m_size, m_addr[1:0]);
                end else begin
                    m_lat = 2;
                    m_rd  = load_ref(ref_mem[m_addr[5:2]], m_size, bus.in_sext, m_addr[1:0]);
                end
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int   k_c;
    logic e_mv;
    logic e_ov;

    always @(negedge clk) begin
        k_c  = cyc - m_acc;
        e_mv = m_busy && (k_c == 0) && !m_mis;
        e_ov = m_busy && (k_c >= m_lat);
        check1("in_ready", bus.in_ready, rst_n && !m_busy);
        check1("mem_valid", bus.mem_valid, e_mv);
        check1("out_valid", bus.out_valid, e_ov);
        if (e_mv) begin
            check("mem_raddr", bus.mem_raddr, {m_addr[31:2], 2'b00});
            check("mem_waddr", bus.mem_waddr, {m_addr[31:2], 2'b00});
            check("mem_wdata", bus.mem_wdata, m_wdata << (8 * int'(m_addr[1:0])));
            check("mem_wmask", 32'(bus.mem_wmask), 32'(mask_ref(m_size, m_addr[1:0])));
            check1("mem_wen", bus.mem_wen, m_wen);
        end else begin
            check("mem_idle_bus", bus.mem_raddr | bus.mem_waddr | bus.mem_wdata | 32'(bus.mem_wmask), 32'h0);
            check1("mem_idle_wen", bus.mem_wen, 1'b0);
        end
        if (e_ov) begin
            check("out_rdata", bus.out_rdata, m_rd);
            check1("out_err", bus.out_err, m_mis);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Runs one transaction from a negedge; returns at the negedge after
    // the response handshake.
    task automatic run_txn(input logic wen, input logic [1:0] size, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                           input logic [31:0] exp_rd, input logic exp_err,
                           output int lat, output logic saw_req, output logic req_wen,
                           output logic [31:0] req_addr, output logic [31:0] req_wdata,
                           output logic [7:0] req_mask);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check1("accept_timeout", 1'b0, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_wen    = wen;
        bus.in_size   = size;
        bus.in_sext   = sext;
        bus.in_addr   = addr;
        bus.in_wdata  = wdata;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1; saw_req = 1'b0; req_wen = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_mask = 8'h00;
        while (!bus.out_valid && lat < 10) begin
            if (bus.mem_valid) begin
                saw_req = 1'b1; req_wen = bus.mem_wen; req_addr = bus.mem_raddr;
                req_wdata = bus.mem_wdata; req_mask = bus.mem_wmask;
            end
            @(negedge clk);
            lat++;
        end
        if (lat >= 10) check1("resp_timeout", 1'b0, 1'b1);
        check("txn_rdata", bus.out_rdata, exp_rd);
        check1("txn_err", bus.out_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check1("hold_valid", bus.out_valid, 1'b1);
            check("hold_rdata", bus.out_rdata, exp_rd);
            check1("hold_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int          lat;
    logic        saw, rwen;
    logic [31:0] ra, rwd;
    logic [7:0]  rm;

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_wen = 1'b0; bus.in_size = 2'b00; bus.in_sext = 1'b0;
        bus.in_addr = 32'h0; bus.in_wdata = 32'h0; bus.out_ready = 1'b0;

        #12;
        check1("rst_in_ready", bus.in_ready, 1'b0);
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_rdata", bus.out_rdata, 32'h0);
        check1("rst_out_err", bus.out_err, 1'b0);
        check1("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_mem_bus", bus.mem_raddr | bus.mem_waddr | bus.mem_wdata | 32'(bus.mem_wmask), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check1("post_rst_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

        // store byte at the top lane
        run_txn(1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00AB, 0, 32'h0, 1'b0,
                lat, saw, rwen, ra, rwd, rm);
        check("sb_lat", 32'(lat), 32'd2);
        check1("sb_req", saw, 1'b1);
        check1("sb_wen", rwen, 1'b1);
        check("sb_waddr", ra, 32'h8000_0000);
        check("sb_wdata", rwd, 32'hAB00_0000);
        check("sb_wmask", 32'(rm), 32'h08);
        check("sb_mem", 32'(env_mem[0][31:24]), 32'hAB);

        // byte loads, signed and unsigned
        preload(4'd0, 32'h1234_8056);
        run_txn(1'b0, 2'b00, 1'b1, 32'h8000_0001, 32'h0, 0, 32'hFFFF_FF80, 1'b0,
                lat, saw, rwen, ra, rwd, rm);
        check("lb_lat", 32'(lat), 32'd3);
        check("lb_raddr", ra, 32'h8000_0000);
        run_txn(1'b0, 2'b00, 1'b0, 32'h8000_0001, 32'h0, 0, 32'h0000_0080, 1'b0,
                lat, saw, rwen, ra, rwd, rm);

        // half and word loads; word load held under backpressure
        preload(4'd0, 32'h8001_ABCD);
        run_txn(1'b0, 2'b01, 1'b1, 32'h8000_0002, 32'h0, 0, 32'hFFFF_8001, 1'b0,
                lat, saw, rwen, ra, rwd, rm);
        run_txn(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, 5, 32'h8001_ABCD, 1'b0,
                lat, saw, rwen, ra, rwd, rm);
        check1("ready_after_hs", bus.in_ready, 1'b1);

        // misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
        run_txn(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, 0, 32'h0, 1'b1,
                lat, saw, rwen, ra, rwd, rm);
        check1("mis_no_req", saw, 1'b0);
        check("mis_lat", 32'(lat), 32'd1);
`else
        run_txn(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, 0, 32'h0000_8001, 1'b0,
                lat, saw, rwen, ra, rwd, rm);
        check1("mis_req", saw, 1'b1);
        check("mis_raddr", ra, 32'h8000_0000);
`endif

        // reset during WAIT
        bus.in_valid = 1'b1; bus.in_wen = 1'b0; bus.in_size = 2'b10; bus.in_addr = 32'h8000_0004;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("rw_in_ready", bus.in_ready, 1'b0);
        check1("rw_out_valid", bus.out_valid, 1'b0);
        check("rw_out_rdata", bus.out_rdata, 32'h0);
        check1("rw_mem_valid", bus.mem_valid, 1'b0);
        check("rw_mem_bus", bus.mem_raddr | bus.mem_waddr | bus.mem_wdata | 32'(bus.mem_wmask), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check1("rw_ready_after", bus.in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check1("rw_no_resp", bus.out_valid, 1'b0);
            @(negedge clk);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_wen    = 1'($urandom_range(0, 1));
            bus.in_size   = 2'($urandom_range(0, 3));
            bus.in_sext   = 1'($urandom_range(0, 1));
            bus.in_addr   = 32'h8000_0000 | 32'($urandom_range(0, 63));
            bus.in_wdata  = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: state %0d", dbg_state);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the core's physical-memory port. It accepts one load or store per transaction from the execute stage and drives the single-cycle synchronous memory port (valid, raddr/rdata, wen, waddr/wdata/wmask). It performs byte-lane alignment, write-mask generation and load sign/zero extension, and holds the result for write-back under a valid/ready handshake. It sits between EXU and WBU, directly in front of the memory model.

## Interface
- No parameters. Data and address width fixed at 32; write mask 8 bits, upper 4 bits always 0.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request from EXU is valid.
- in_ready  out  1  LSU can accept a request.
- in_wen  in  1  1 = store, 0 = load.
- in_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- in_sext  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, right-aligned.
- out_valid  out  1  result available to WBU.
- out_ready  in  1  WBU accepts the result.
- out_rdata  out  32  extended load data; 0 for stores.
- out_err  out  1  misaligned access (LSU_MISALIGN_CHECK_EN only, else constant 0).
- mem_valid  out  1  memory request strobe.
- mem_raddr  out  32  word-aligned read address.
- mem_rdata  in  32  read data, valid in the cycle after mem_valid.
- mem_wen  out  1  write enable, only together with mem_valid.
- mem_waddr  out  32  word-aligned write address.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  8  byte-lane mask.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- IDLE: in_ready=1. When in_valid is high at a clock edge, latch wen/size/sext/addr/wdata and go to REQ.
- REQ: mem_valid=1 for exactly one cycle. mem_raddr = mem_waddr = {addr[31:2],2'b00}. mem_wen = latched wen.
  - mem_wmask[3:0] = base << addr[1:0], truncated to 4 bits. base is 0001 (byte), 0011 (half) or 1111 (word).
  - mem_wdata = wdata << {addr[1:0],3'b000}.
  - Next state: store -> RESP; load -> WAIT.
- WAIT: sample mem_rdata. Compute sh = mem_rdata >> {addr[1:0],3'b000}.
  - Byte extends sh[7:0]; half extends sh[15:0]; word passes sh unchanged. Extension follows sext.
  - Register the result into out_rdata and go to RESP.
- RESP: out_valid=1. out_rdata and out_err are held stable. When out_ready is high at a clock edge, go to IDLE.
- A new request is accepted only in IDLE. There is no pipelining; one transaction is outstanding at a time.
- Whenever mem_valid=0: mem_wen=0, mem_wmask=0, and address/data outputs are 0.

## Timing
- Reset (asserted at any time, including mid-transaction):
  - Takes effect immediately; state goes to IDLE and the in-flight transaction is dropped with no response.
  - Reset values: in_ready=0 while rst_n=0, then 1; out_valid=0; out_rdata=0; out_err=0.
  - Reset values: mem_valid=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, mem_wmask=0.
- Load: accepted at edge E0. mem_valid is high in cycle E0..E1. Data is sampled in E1..E2. out_valid rises after E2 (3 cycles after accept).
- Store: out_valid rises 2 cycles after accept.
- out_valid stays high with stable outputs until out_ready is sampled high. out_ready=1 in the first RESP cycle gives zero-wait completion. The next accept is possible at the following edge at the earliest.
- in_valid while not in IDLE is ignored; in_ready=0 in REQ, WAIT and RESP.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - A misaligned access goes IDLE -> RESP directly, never asserts mem_valid, and reports out_err=1, out_rdata=0.
  - out_err is cleared on the out_ready handshake.
- LSU_MISALIGN_CHECK_EN undefined:
  - No check is made and out_err is tied 0.
  - Misaligned accesses are issued with the shift/truncate rules above; lanes beyond byte 3 are dropped.

## Test plan
- Store byte: in_addr 0x80000003, in_wdata 0x000000AB -> one REQ cycle with mem_waddr 0x80000000, mem_wdata 0xAB000000, mem_wmask 0x08, mem_wen=1; out_valid 2 cycles after accept.
- Load byte from 0x80000001 with mem_rdata 0x12348056: sext=1 -> out_rdata 0xFFFFFF80; sext=0 -> 0x00000080; out_valid 3 cycles after accept.
- Load half from 0x80000002 with mem_rdata 0x8001ABCD, sext=1 -> out_rdata 0xFFFF8001; load word from 0x80000000 -> 0x8001ABCD.
- Backpressure: out_ready held 0 for 5 cycles -> out_valid, out_rdata stable and in_ready=0 throughout; next request accepted the cycle after the handshake.
- Misaligned word load at 0x80000002 with LSU_MISALIGN_CHECK_EN -> mem_valid never asserted, out_err=1, out_rdata=0; without the macro -> mem_raddr 0x80000000, out_rdata = mem_rdata>>16.
- rst_n pulsed low during WAIT -> all outputs go to reset values immediately, no out_valid afterwards; in_ready=1 on the first cycle after release.
